// File: rtl/sq_sched_pkg.sv
// sq_sched_pkg: shared types and constants for the sq_rd round-robin scheduler.
// Contents:
//   sched_state_t : flush/drain state machine encoding
//   DESC_*        : bit offsets of the fields inside an 80-bit read descriptor
//   cnt_width()   : width of a credit counter able to hold 0..max_out
package sq_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

    localparam int DESC_VADDR_LSB  = 0;
    localparam int DESC_VADDR_MSB  = 47;
    localparam int DESC_LEN_LSB    = 48;
    localparam int DESC_LEN_MSB    = 75;
    localparam int DESC_STREAM_LSB = 76;
    localparam int DESC_STREAM_MSB = 77;
    localparam int DESC_LAST_BIT   = 78;
    localparam int DESC_RSVD_BIT   = 79;

    // Counter must represent the full-credit value max_out itself.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: purely combinational rotating-priority arbiter.
// Ports:
//   req          in  N      request vector
//   ptr          in  IDX_W  index with highest priority this cycle
//   grant_onehot out N      one-hot winner (all zero when no request)
//   grant_idx    out IDX_W  binary winner index (0 when no request)
//   any          out 1      at least one request present
module rr_arbiter_n #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_rot;
    logic [IDX_W:0] w_sum;

    assign w_dbl = {req, req};

    // Rotate requests so ptr sits at bit 0, pick the lowest set bit, map back.
    always_comb begin
        w_rot = w_dbl >> ptr;
        w_sum = {(IDX_W+1){1'b0}};
        any   = 1'b0;
        // Descending scan: the last hit (lowest offset from ptr) wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
                any   = 1'b1;
            end else begin
                w_sum = w_sum;
            end
        end
        if (w_sum >= (IDX_W+1)'(N)) begin
            w_sum = w_sum - (IDX_W+1)'(N);
        end else begin
            w_sum = w_sum;
        end
        grant_idx    = w_sum[IDX_W-1:0];
        grant_onehot = any ? (N'(1'b1) << w_sum) : {N{1'b0}};
    end

endmodule

// File: rtl/sq_rr_sched.sv
// sq_rr_sched: shares one sq_rd descriptor queue among N_REQ requesters with
// round-robin arbitration, per-requester credit limits and a flush handshake.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   req_valid/ready/data per-requester descriptor handshake (slice i = requester i)
//   sq_valid/ready/data  registered descriptor towards sq_rd; sq_dest = requester index
//   cq_valid, cq_dest    completion strobe returning one credit to cq_dest
//   flush, flush_done    drain request level / one-cycle drained pulse
//   busy                 credits outstanding or descriptor held
//   err_cq               sticky: completion for an idle or out-of-range requester
module sq_rr_sched
    import sq_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int REQ_BITS = 80,
    parameter int MAX_OUT  = 8,
    parameter int ID_BITS  = 3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*REQ_BITS-1:0] req_data,
    output logic                      sq_valid,
    input  logic                      sq_ready,
    output logic [REQ_BITS-1:0]       sq_data,
    output logic [ID_BITS-1:0]        sq_dest,
    input  logic                      cq_valid,
    input  logic [ID_BITS-1:0]        cq_dest,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy,
    output logic                      err_cq
);

    localparam int CNT_W = cnt_width(MAX_OUT);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [CNT_W-1:0]     r_cnt     [N_REQ];
    logic [CNT_W-1:0]     w_cnt_nxt [N_REQ];
    logic [ID_BITS-1:0]   r_ptr;
    logic                 r_sq_valid;
    logic [REQ_BITS-1:0]  r_sq_data;
    logic [ID_BITS-1:0]   r_sq_dest;
    logic                 r_flush_done;
    logic                 r_busy;
    logic                 r_err_cq;

    logic [N_REQ-1:0]     w_elig;
    logic [N_REQ-1:0]     w_grant_oh;
    logic [ID_BITS-1:0]   w_grant_idx;
    logic                 w_grant_any;
    logic                 w_slot_load;
    logic                 w_hs;
    logic                 w_cq_hit;
    logic                 w_cq_err;
    logic                 w_all_zero;
    logic                 w_any_nxt;
    logic                 w_sq_valid_nxt;
    logic [ID_BITS-1:0]   w_ptr_nxt;

    // Eligibility: pending request, spare credit, running and no flush this cycle.
    always_comb begin
        w_elig = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUT)) && (r_state == RUN) && !flush) begin
                w_elig[i] = 1'b1;
            end else begin
                w_elig[i] = 1'b0;
            end
        end
    end

    rr_arbiter_n #(
        .N     (N_REQ),
        .IDX_W (ID_BITS)
    ) u_arb (
        .req          (w_elig),
        .ptr          (r_ptr),
        .grant_onehot (w_grant_oh),
        .grant_idx    (w_grant_idx),
        .any          (w_grant_any)
    );

    // The output slot can take a new descriptor when empty or being drained now.
    assign w_slot_load    = !r_sq_valid || sq_ready;
    // Ready is masked while reset is held so nothing is accepted into a cleared slot.
    assign req_ready      = (aresetn && w_slot_load) ? w_grant_oh : {N_REQ{1'b0}};
    assign w_hs           = w_slot_load && w_grant_any;
    assign w_sq_valid_nxt = w_slot_load ? w_grant_any : r_sq_valid;
    assign w_ptr_nxt      = (w_grant_idx == ID_BITS'(N_REQ - 1)) ? ID_BITS'(0)
                                                                 : (w_grant_idx + ID_BITS'(1));

    // Credit bookkeeping: grant adds, completion removes, both together cancel.
    always_comb begin
        logic v_inc;
        logic v_dec;
        v_inc      = 1'b0;
        v_dec      = 1'b0;
        w_cq_hit   = 1'b0;
        w_all_zero = 1'b1;
        w_any_nxt  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            v_inc      = w_hs && (w_grant_idx == ID_BITS'(i));
            v_dec      = cq_valid && (cq_dest == ID_BITS'(i)) && (r_cnt[i] != CNT_W'(0));
            w_cq_hit   = w_cq_hit | v_dec;
            w_all_zero = w_all_zero & (r_cnt[i] == CNT_W'(0));
            case ({v_inc, v_dec})
                2'b10:   w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
            w_any_nxt = w_any_nxt | (w_cnt_nxt[i] != CNT_W'(0));
        end
        // Any completion that did not match a requester holding credit is an error.
        w_cq_err = cq_valid && !w_cq_hit;
    end

    // Flush state machine next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (flush) w_state_nxt = DRAIN;
                else       w_state_nxt = RUN;
            end
            DRAIN: begin
                if (!r_sq_valid && w_all_zero) w_state_nxt = DONE;
                else                           w_state_nxt = DRAIN;
            end
            DONE: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!flush) w_state_nxt = RUN;
                else        w_state_nxt = HOLD;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Per-requester credit counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= CNT_W'(0);
        end else begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    // State, pointer, output slot and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= RUN;
            r_ptr        <= ID_BITS'(0);
            r_sq_valid   <= 1'b0;
            r_sq_data    <= REQ_BITS'(0);
            r_sq_dest    <= ID_BITS'(0);
            r_flush_done <= 1'b0;
            r_busy       <= 1'b0;
            r_err_cq     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sq_valid   <= w_sq_valid_nxt;
            r_flush_done <= (w_state_nxt == DONE);
            r_busy       <= w_any_nxt || w_sq_valid_nxt;
            r_err_cq     <= r_err_cq || w_cq_err;
            if (w_hs) begin
                r_sq_data <= req_data[w_grant_idx * REQ_BITS +: REQ_BITS];
                r_sq_dest <= w_grant_idx;
                r_ptr     <= w_ptr_nxt;
            end else begin
                r_sq_data <= r_sq_data;
                r_sq_dest <= r_sq_dest;
                r_ptr     <= r_ptr;
            end
        end
    end

    assign sq_valid   = r_sq_valid;
    assign sq_data    = r_sq_data;
    assign sq_dest    = r_sq_dest;
    assign flush_done = r_flush_done;
    assign busy       = r_busy;
    assign err_cq     = r_err_cq;

endmodule

// File: doc/sq_rr_sched.md
Name: sq_rr_sched

Overview:
- Shares the single vFPGA read-descriptor queue (sq_rd) among N_REQ user-logic requesters.
- Grants requesters round-robin and limits each requester's outstanding descriptors using per-requester credit counters.
- Returns credits when completions arrive on cq_rd; completions are tagged with the requester index in the descriptor dest field.
- Sits between user kernels and the sq_rd/cq_rd ports of design_user_logic_c0_*, and supports a drain/flush handshake for the host control path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- REQ_BITS, 80, descriptor payload width: vaddr[47:0], len[75:48], stream[77:76], last[78], rsvd[79].
- MAX_OUT, 8, maximum outstanding descriptors per requester (power of two, ≤ 16).
- ID_BITS, 3, width of the requester index carried in dest; must satisfy 2^ID_BITS ≥ N_REQ.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester descriptor valid
- req_ready  out  N_REQ  per-requester accept
- req_data  in  N_REQ*REQ_BITS  packed descriptors, requester i occupies slice i
- sq_valid  out  1  descriptor to sq_rd
- sq_ready  in  1  sq_rd accept
- sq_data  out  REQ_BITS  granted descriptor
- sq_dest  out  ID_BITS  granted requester index
- cq_valid  in  1  completion strobe from cq_rd (always accepted, no ready)
- cq_dest  in  ID_BITS  completing requester index
- flush  in  1  level request: stop granting and drain
- flush_done  out  1  one-cycle pulse when drained
- busy  out  1  any counter nonzero or sq_valid high
- err_cq  out  1  sticky: completion for an idle or out-of-range requester

Behaviour:
- Reset (asynchronous, aresetn=0) applies immediately, also mid-transfer:
  - sq_valid=0, sq_data=0, sq_dest=0, req_ready=0, flush_done=0, err_cq=0, busy=0.
  - All credit counters cleared to 0; round-robin pointer = 0; state = RUN.
  - An in-flight descriptor is dropped, not replayed.
- Output stage: sq_valid/sq_data/sq_dest are registered. The slot may load when (!sq_valid || sq_ready), which sustains 1 descriptor per cycle.
- Eligibility: requester i is eligible when req_valid[i] && cnt[i] < MAX_OUT && state == RUN.
- Arbitration:
  - Search eligible requesters starting at ptr, wrapping N_REQ-1 → 0.
  - Winner w gets req_ready[w]=1, combinational, only in a cycle where the slot may load; all other req_ready bits are 0.
  - req_ready never depends combinationally on req_valid of the same requester.
  - On handshake: sq_data ← req_data[w], sq_dest ← w, sq_valid ← 1, cnt[w]++, ptr ← (w+1) mod N_REQ.
- Latency: request accepted in cycle N → sq_valid=1 in cycle N+1.
- Holding: sq_valid and its data remain stable until sq_ready. If the slot empties with no new grant, sq_valid ← 0.
- Completion: cq_valid with cq_dest=d decrements cnt[d].
  - A grant and a completion on the same requester in the same cycle leave cnt unchanged.
  - Completion when cnt[d]==0 or d ≥ N_REQ: counter unchanged, err_cq set. err_cq clears only on reset.
- Full credit: when cnt[i]==MAX_OUT, requester i is skipped without stalling the others; it becomes eligible the cycle after its completion.
- State machine:
  - RUN: normal granting. flush=1 → DRAIN; no new grants from that cycle on.
  - DRAIN: the held descriptor still completes its sq handshake. When sq_valid==0 and all cnt==0, go to DONE.
  - DONE: flush_done=1 for exactly one cycle, then go to HOLD.
  - HOLD: no grants. flush=0 → RUN.
  - Flush asserted while already drained: RUN → DRAIN → DONE, so the pulse comes 2 cycles after flush rises.
- busy: registered OR of all (cnt≠0) and sq_valid.

Decomposition:
- Shared package (lynxTypes extension), sq_sched_pkg: typedef sched_state_t {RUN, DRAIN, DONE, HOLD}; the descriptor field offsets; a MAX_OUT counter width function clog2(MAX_OUT+1).
- One sub-module, rr_arbiter_n: parameter N; ports req[N], ptr, grant_onehot, grant_idx, any. Purely combinational priority rotate.
- The top module holds the counters, the output register and the FSM.

Test Plan:
- Req0 and req2 hold valid with sq_ready=1 constant → sq_dest alternates 0,2,0,2 at one descriptor per cycle. First sq_valid appears one cycle after the first req_ready.
- Req1 issues 8 descriptors with no completions (MAX_OUT=8) → req_ready[1] stays 0 afterward while req3 is still granted. One cq_dest=1 → req1 is granted the following cycle.
- sq_ready=0 for 5 cycles with a descriptor loaded (vaddr=0x1000, len=64) → sq_data stable, no req_ready, cnt unchanged. sq_ready=1 → a new grant the same cycle.
- Grant to req0 and cq_dest=0 in the same cycle with cnt[0]=3 → cnt[0] stays 3. cq_dest=2 with cnt[2]=0 → err_cq=1, counters unchanged.
- 3 outstanding, flush=1 → no further req_ready. After 3 completions → flush_done pulses once. flush=0 → granting resumes from the saved ptr.
- aresetn=0 asynchronously mid-stream with sq_valid=1 → sq_valid=0 immediately, busy=0, all counters 0. After release, the first grant goes to requester 0.
